// File: rtl/peak_detector_if.sv
// Slope-in / event-out bundle for peak_detector. The slave side is the detector;
// the master side is whoever feeds slopes and drains event records.
interface peak_detector_if #(
  parameter int N  = 8,
  parameter int TW = 16
) ();
  logic signed [N-1:0] din;
  logic                din_valid;
  logic                ev_valid;
  logic                ev_ready;
  logic signed [N-1:0] ev_slope;
  logic [7:0]          ev_width;
  logic [TW-1:0]       ev_time;

  modport master (
    output din, din_valid, ev_ready,
    input  ev_valid, ev_slope, ev_width, ev_time
  );

  modport slave (
    input  din, din_valid, ev_ready,
    output ev_valid, ev_slope, ev_width, ev_time
  );
endinterface

// File: rtl/peak_detector.sv
// Rising-slope pulse detector with a one-entry event buffer and post-event hold-off.
// Define PEAK_TIMESTAMP_EN to stamp events with the terminating sample index.
module peak_detector #(
  parameter int N       = 8,
  parameter int TW      = 16,
  parameter int HOLDOFF = 4
) (
  input  logic                clk,
  input  logic                reset,
  peak_detector_if.slave      bus,
  input  logic signed [N-1:0] thresh_i,
  output logic                overflow_o,
  output logic                busy_o
);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic signed [N-1:0] ZERO = '0;
  localparam logic signed [N-1:0] ONE  = N'(1);

  typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;

  state_t              state_q, state_d;
  logic signed [N-1:0] max_q, max_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic                emit;

  logic                evv_q, evv_d;
  logic signed [N-1:0] evs_q, evs_d;
  logic [7:0]          evw_q, evw_d;
  logic [TW-1:0]       evt_q, evt_d;
  logic                ovf_q, ovf_d;

  logic signed [N-1:0] din_s, th;
  logic [TW-1:0]       ts;

  assign din_s = bus.din;
  // Non-positive thresholds would arm on flat or falling slopes; clamp to 1.
  assign th    = (thresh_i > ZERO) ? thresh_i : ONE;

`ifdef PEAK_TIMESTAMP_EN
  logic [TW-1:0] scnt_q;
  always_ff @(posedge clk) begin
    if (reset)              scnt_q <= '0;
    else if (bus.din_valid) scnt_q <= scnt_q + TW'(1);
  end
  assign ts = scnt_q;
`else
  assign ts = '0;
`endif

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    emit    = 1'b0;
    if (bus.din_valid) begin
      unique case (state_q)
        IDLE: if (din_s >= th) begin
          state_d = RISE;
          max_d   = din_s;
          cnt_d   = 8'd1;
        end
        RISE: if (din_s > ZERO) begin
          if (din_s > max_q)   max_d = din_s;
          if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
        end else begin
          emit    = 1'b1;
          hcnt_d  = '0;
          state_d = (HOLDOFF > 0) ? HOLD : IDLE;
        end
        HOLD: if (hcnt_q == HW'(HOLDOFF - 1)) state_d = IDLE;
              else                            hcnt_d  = hcnt_q + HW'(1);
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop and a push on the same edge leave the buffer full with the new record.
  always_comb begin
    evv_d = evv_q & ~bus.ev_ready;
    evs_d = evs_q;
    evw_d = evw_q;
    evt_d = evt_q;
    ovf_d = ovf_q;
    if (emit) begin
      if (!evv_q || bus.ev_ready) begin
        evv_d = 1'b1;
        evs_d = max_q;
        evw_d = cnt_q;
        evt_d = ts;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      max_q   <= '0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      evv_q   <= 1'b0;
      evs_q   <= '0;
      evw_q   <= '0;
      evt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      evv_q   <= evv_d;
      evs_q   <= evs_d;
      evw_q   <= evw_d;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ev_valid = evv_q;
  assign bus.ev_slope = evs_q;
  assign bus.ev_width = evw_q;
  assign bus.ev_time  = evt_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_peak_detector.sv
// Bench for peak_detector: one instance with hold-off 4, one with hold-off 0,
// both fed identical stimulus and checked against a pulse-level reference model.
module tb_peak_detector;
`ifdef PEAK_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [7:0] din = '0;
  logic dv = 1'b0, rdy = 1'b0;
  logic signed [7:0] thresh = 8'sd10;
  logic ovf4, busy4, ovf0, busy0;

  always #5 clk = ~clk;

  peak_detector_if #(.N(8), .TW(16)) if4 ();
  peak_detector_if #(.N(8), .TW(16)) if0 ();

  assign if4.din = din;  assign if4.din_valid = dv;  assign if4.ev_ready = rdy;
  assign if0.din = din;  assign if0.din_valid = dv;  assign if0.ev_ready = rdy;

  peak_detector #(.N(8), .TW(16), .HOLDOFF(4)) dut4 (
    .clk(clk), .reset(rst), .bus(if4), .thresh_i(thresh), .overflow_o(ovf4), .busy_o(busy4));
  peak_detector #(.N(8), .TW(16), .HOLDOFF(0)) dut0 (
    .clk(clk), .reset(rst), .bus(if0), .thresh_i(thresh), .overflow_o(ovf0), .busy_o(busy0));

  int n_cmp = 0, n_bad = 0;

  // Reference model: a pulse is tracked by its running peak and length,
  // hold-off by samples remaining; the buffer is a single optional record.
  int HO[2] = '{4, 0};
  bit m_in[2], m_bv[2], m_ovf[2];
  int m_mx[2], m_len[2], m_hold[2], m_bs[2], m_bw[2], m_bt[2];
  int m_cnt;

  task automatic model_edge();
    int th, d, es, ew, et;
    bit ev;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_in[i] = 0; m_bv[i] = 0; m_ovf[i] = 0; m_hold[i] = 0; m_len[i] = 0; m_mx[i] = 0;
      end
      m_cnt = 0;
      return;
    end
    th = (int'(thresh) > 0) ? int'(thresh) : 1;
    d  = int'(din);
    for (int i = 0; i < 2; i++) begin
      ev = 0; es = 0; ew = 0; et = 0;
      if (dv) begin
        if (m_hold[i] > 0) m_hold[i]--;
        else if (m_in[i]) begin
          if (d > 0) begin
            m_len[i]++;
            if (d > m_mx[i]) m_mx[i] = d;
          end else begin
            ev = 1; es = m_mx[i];
            ew = (m_len[i] > 255) ? 255 : m_len[i];
            et = TS_EN ? (m_cnt % 65536) : 0;
            m_in[i] = 0; m_hold[i] = HO[i];
          end
        end else if (d >= th) begin
          m_in[i] = 1; m_mx[i] = d; m_len[i] = 1;
        end
      end
      if (ev) begin
        if (!m_bv[i] || rdy) begin
          m_bv[i] = 1; m_bs[i] = es; m_bw[i] = ew; m_bt[i] = et;
        end else m_ovf[i] = 1;
      end else if (m_bv[i] && rdy) m_bv[i] = 0;
    end
    if (dv) m_cnt++;
  endtask

  task automatic get_act(input int i, output logic v, output int s, output int w,
                         output int t, output logic o, output logic b);
    if (i == 0) begin
      v = if4.ev_valid; s = int'(if4.ev_slope); w = int'(if4.ev_width);
      t = int'(if4.ev_time); o = ovf4; b = busy4;
    end else begin
      v = if0.ev_valid; s = int'(if0.ev_slope); w = int'(if0.ev_width);
      t = int'(if0.ev_time); o = ovf0; b = busy0;
    end
  endtask

  task automatic check_model();
    logic v, o, b;
    int s, w, t;
    bit eb;
    for (int i = 0; i < 2; i++) begin
      get_act(i, v, s, w, t, o, b);
      eb = m_in[i] || (m_hold[i] > 0);
      n_cmp++;
      if (v !== m_bv[i] || o !== m_ovf[i] || b !== eb ||
          (m_bv[i] && (s != m_bs[i] || w != m_bw[i] || t != m_bt[i]))) begin
        n_bad++;
        $display("FAIL model[ho=%0d] @%0t: got v=%b s=%0d w=%0d t=%0d ovf=%b busy=%b, want v=%b s=%0d w=%0d t=%0d ovf=%b busy=%b",
                 HO[i], $time, v, s, w, t, o, b, m_bv[i], m_bs[i], m_bw[i], m_bt[i], m_ovf[i], eb);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic samp(input int d, input bit r);
    din = 8'(d); dv = 1'b1; rdy = r; rst = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; dv = 1'b0; rdy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".v4"},    int'(if4.ev_valid), 0);
    chk({nm, ".s4"},    int'(if4.ev_slope), 0);
    chk({nm, ".w4"},    int'(if4.ev_width), 0);
    chk({nm, ".t4"},    int'(if4.ev_time),  0);
    chk({nm, ".ovf4"},  int'(ovf4),         0);
    chk({nm, ".busy4"}, int'(busy4),        0);
    chk({nm, ".v0"},    int'(if0.ev_valid), 0);
    chk({nm, ".ovf0"},  int'(ovf0),         0);
    chk({nm, ".busy0"}, int'(busy0),        0);
  endtask

  typedef struct {
    int din; bit ready;
    bit ev_valid; int slope; int width; int tstamp; bit busy;
  } vec_t;
  vec_t tbl[11];

  initial begin
    // Basic pulse on the hold-off-4 instance, thresh=10, consumer always ready.
    tbl[0]  = '{0,   1, 0, 0,  0, 0, 0};
    tbl[1]  = '{5,   1, 0, 0,  0, 0, 0};
    tbl[2]  = '{12,  1, 0, 0,  0, 0, 1};
    tbl[3]  = '{30,  1, 0, 0,  0, 0, 1};
    tbl[4]  = '{20,  1, 0, 0,  0, 0, 1};
    tbl[5]  = '{-3,  1, 1, 30, 3, 5, 1};
    tbl[6]  = '{0,   1, 0, 0,  0, 0, 1};
    tbl[7]  = '{0,   1, 0, 0,  0, 0, 1};
    tbl[8]  = '{50,  1, 0, 0,  0, 0, 1};
    tbl[9]  = '{0,   1, 0, 0,  0, 0, 0};
    tbl[10] = '{0,   1, 0, 0,  0, 0, 0};

    thresh = 8'sd10;
    do_reset();
    chk_reset("reset");

    for (int k = 0; k < 11; k++) begin
      samp(tbl[k].din, tbl[k].ready);
      chk($sformatf("basic[%0d].valid", k), int'(if4.ev_valid), int'(tbl[k].ev_valid));
      chk($sformatf("basic[%0d].busy", k),  int'(busy4),        int'(tbl[k].busy));
      if (tbl[k].ev_valid) begin
        chk("basic.slope", int'(if4.ev_slope), tbl[k].slope);
        chk("basic.width", int'(if4.ev_width), tbl[k].width);
        chk("basic.time",  int'(if4.ev_time),  TS_EN ? tbl[k].tstamp : 0);
      end
    end

    // Threshold edge: exactly thresh arms, one below does not.
    samp(10, 1); samp(0, 1);
    chk("thr.valid", int'(if4.ev_valid), 1);
    chk("thr.slope", int'(if4.ev_slope), 10);
    chk("thr.width", int'(if4.ev_width), 1);
    for (int k = 0; k < 4; k++) samp(0, 1);
    samp(9, 1); samp(0, 1);
    chk("thr_below.valid4", int'(if4.ev_valid), 0);
    chk("thr_below.valid0", int'(if0.ev_valid), 0);

    // Backpressure: second pulse on the hold-off-0 instance is dropped.
    samp(20, 0); samp(-1, 0); samp(40, 0); samp(0, 0);
    chk("bp.ovf0",   int'(ovf0),          1);
    chk("bp.valid0", int'(if0.ev_valid),  1);
    chk("bp.slope0", int'(if0.ev_slope),  20);
    chk("bp.ovf4",   int'(ovf4),          0);
    dv = 1'b0; rdy = 1'b1; tick();
    chk("bp_drain.valid0", int'(if0.ev_valid), 0);
    chk("bp_drain.ovf0",   int'(ovf0),         1);

    // Simultaneous pop and push.
    do_reset();
    chk("pp.ovf_cleared", int'(ovf0), 0);
    samp(20, 0); samp(-1, 0); samp(40, 0); samp(0, 1);
    chk("pp.valid0", int'(if0.ev_valid), 1);
    chk("pp.slope0", int'(if0.ev_slope), 40);
    chk("pp.time0",  int'(if0.ev_time),  TS_EN ? 3 : 0);
    chk("pp.ovf0",   int'(ovf0),         0);

    // Reset in the middle of a rise.
    for (int k = 0; k < 5; k++) samp(0, 1);
    samp(20, 1); samp(30, 1);
    din = -8'sd1; dv = 1'b1; rdy = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midrise");
    samp(20, 1); samp(-1, 1);
    chk("post_rst.valid", int'(if4.ev_valid), 1);
    chk("post_rst.slope", int'(if4.ev_slope), 20);
    chk("post_rst.time",  int'(if4.ev_time),  TS_EN ? 1 : 0);

    // Negative threshold acts as 1.
    thresh = -8'sd5;
    for (int k = 0; k < 5; k++) samp(0, 1);
    chk("neg.no_arm4", int'(busy4), 0);
    chk("neg.no_arm0", int'(busy0), 0);
    samp(1, 1);
    chk("neg.arm", int'(busy4), 1);
    samp(0, 1);
    chk("neg.slope", int'(if4.ev_slope), 1);
    chk("neg.width", int'(if4.ev_width), 1);

    // Width saturation.
    thresh = 8'sd10;
    for (int k = 0; k < 5; k++) samp(0, 1);
    for (int k = 0; k < 300; k++) samp(100, 1);
    samp(-128, 1);
    chk("sat.valid", int'(if4.ev_valid), 1);
    chk("sat.width", int'(if4.ev_width), 255);
    chk("sat.slope", int'(if4.ev_slope), 100);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      rst = ($urandom_range(0, 199) == 0);
      dv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      r = int'($urandom_range(0, 9));
      if (r < 4)      din = 8'($urandom_range(0, 40));
      else if (r < 7) din = 8'($urandom_range(0, 255));
      else            din = 8'(-int'($urandom_range(0, 5)));
      if ($urandom_range(0, 99) == 0) thresh = 8'($urandom_range(0, 255));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
